commit_unit: RTL and testbench
==============================

COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 2, number of cycles flush stays asserted after a mispredict commit (range 1..15).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 is_empty  input  1  ROB has no entries.
REQ-005 head_ready  input  1  ROB head entry has finished.
REQ-006 head_instr  input  32  ROB head instruction word.
REQ-007 head_val  input  32  ROB head result (reg data / store data / redirect target).
REQ-008 stall  input  1  commit inhibit; no new commit starts while high.
REQ-009 st_ack  input  1  store buffer accepted the committed store.
REQ-010 pop  output  1  retire ROB head on this rising edge; combinational.
REQ-011 rf_we, rf_waddr, rf_wdata  output  1/5/32  architectural register write, combinational, valid with pop.
REQ-012 st_commit  output  1  registered request to store buffer; held until st_ack.
REQ-013 flush  output  1  registered pipeline/ROB flush.
REQ-014 redirect_pc  output  32  registered fetch target, valid while flush high.
REQ-015 commit_count  output  32  registered count of retired instructions.

Function
REQ-016 Opcode = head_instr[31:27], rd = head_instr[26:22]; classes: REG (00000 ALU, 00101 addi, 01000 lw), LINK (00011 jal -> r31), SETX (10101 -> r30), STORE (00111 sw), CTRL (00001 j, 00010 bne, 00100 jr, 00110 blt, 10110 bex); any other opcode retires as NOP.
REQ-017 States: RUN, STORE_WAIT, FLUSH.
REQ-018 "Eligible" = state RUN and !is_empty and head_ready and !stall.
REQ-019 RUN, eligible, REG/LINK/SETX/NOP: pop=1 same cycle; rf_we=1 with rf_waddr=rd (31 for LINK, 30 for SETX), rf_wdata=head_val; stay RUN.
REQ-020 Writes to register 0 SHALL be suppressed (rf_we=0) while pop still asserts.
REQ-021 RUN, eligible, STORE: pop=0; next cycle st_commit=1, state STORE_WAIT.
REQ-022 STORE_WAIT: st_commit held 1; when st_ack=1, pop=1 that cycle, st_commit=0 next cycle, state RUN; stall ignored in STORE_WAIT.
REQ-023 RUN, eligible, CTRL: pop=1; if head_val = 0xFFFFFFFF (prediction correct) stay RUN; else redirect_pc<=head_val, flush<=1, state FLUSH.
REQ-024 FLUSH: pop=0, rf_we=0; flush held exactly FLUSH_CYCLES cycles, then flush=0, state RUN.
REQ-025 commit_count increments by 1 on every cycle pop=1, wraps 0xFFFFFFFF -> 0.
REQ-026 pop SHALL never assert when is_empty=1 or head_ready=0 (including STORE_WAIT, where st_ack with empty ROB is ignored).
REQ-027 At most one retirement per cycle; rf_we=1 only when pop=1.

Reset
REQ-028 reset=0 at a rising edge: state RUN, st_commit=0, flush=0, redirect_pc=0, commit_count=0, flush counter 0; an in-flight store or flush is abandoned.
REQ-029 While reset=0, pop and rf_we SHALL be 0.

Structure
REQ-030 Opcode constants, class encoding, state encoding and the 0xFFFFFFFF no-redirect constant belong in the shared OoO package.
REQ-031 One sub-module, commit_decode: combinational opcode -> class / destination register mapping.

Verification
REQ-032 ROB head addi rd=5, val 0x1234, ready -> same-cycle pop=1, rf_we=1, waddr=5, wdata=0x1234; commit_count 0->1.
REQ-033 Head ALU rd=0, ready -> pop=1, rf_we=0.
REQ-034 Head sw ready, st_ack low 3 cycles then high -> st_commit high 4 cycles, pop=1 only in the st_ack cycle, count +1.
REQ-035 Head bne with head_val=0x00000040 -> pop=1, then flush=1 for 2 cycles with redirect_pc=0x40, no pops during flush; head_val=0xFFFFFFFF -> no flush.
REQ-036 Head ready but is_empty=1, or stall=1 -> pop=0 indefinitely; reset asserted during STORE_WAIT -> st_commit=0, count=0 next cycle.

Source files
------------

// File: rtl/commit_unit_pkg.sv
// Shared commit-stage definitions: opcodes, instruction classes,
// commit FSM states and the no-redirect marker.
package commit_unit_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam logic [4:0] REG_LINK = 5'd31;
  localparam logic [4:0] REG_SETX = 5'd30;

  localparam logic [31:0] NO_REDIRECT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_REG,
    CLS_LINK,
    CLS_SETX,
    CLS_STORE,
    CLS_CTRL
  } cls_e;

  typedef enum logic [1:0] {
    S_RUN,
    S_STORE_WAIT,
    S_FLUSH
  } state_e;

endpackage

// File: rtl/commit_decode.sv
// Head instruction classifier: opcode to retirement class and
// destination register.
module commit_decode
  import commit_unit_pkg::*;
(
  input  logic [9:0] instr_hi,
  output cls_e       cls,
  output logic [4:0] dest
);

  logic [4:0] op;
  logic [4:0] rd;

  assign op = instr_hi[9:5];
  assign rd = instr_hi[4:0];

  always_comb begin
    cls  = CLS_NOP;
    dest = rd;
    unique case (1'b1)
      (op == OP_ALU) || (op == OP_ADDI) || (op == OP_LW):
        cls = CLS_REG;
      (op == OP_JAL): begin
        cls  = CLS_LINK;
        dest = REG_LINK;
      end
      (op == OP_SETX): begin
        cls  = CLS_SETX;
        dest = REG_SETX;
      end
      (op == OP_SW):
        cls = CLS_STORE;
      (op == OP_J) || (op == OP_BNE) || (op == OP_JR) ||
      (op == OP_BLT) || (op == OP_BEX):
        cls = CLS_CTRL;
      default:
        cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/commit_unit.sv
// In-order commit stage: retires the ROB head, drives register writes,
// hands stores to the store buffer and flushes on mispredicts.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        is_empty,
  input  logic        head_ready,
  input  logic [31:0] head_instr,
  input  logic [31:0] head_val,
  input  logic        stall,
  input  logic        st_ack,
  output logic        pop,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        st_commit,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] commit_count
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_e     state;
  logic [3:0] fcnt;
  cls_e       cls;
  logic [4:0] dest;
  logic       head_ok;
  logic       eligible;
  logic       mispredict;
  logic       unused;

  assign unused = ^head_instr[21:0];

  commit_decode u_decode (
    .instr_hi (head_instr[31:22]),
    .cls      (cls),
    .dest     (dest)
  );

  assign head_ok    = !is_empty && head_ready;
  assign eligible   = reset && (state == S_RUN) &&
                      head_ok && !stall;
  assign mispredict = (head_val != NO_REDIRECT);

  always_comb begin
    pop      = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = dest;
    rf_wdata = head_val;
    if (eligible) begin
      case (cls)
        CLS_REG, CLS_LINK, CLS_SETX, CLS_NOP: begin
          pop   = 1'b1;
          rf_we = (dest != 5'd0);
        end
        CLS_CTRL: pop = 1'b1;
        default:  pop = 1'b0;
      endcase
    end
    // store retires only once the buffer takes it and the head is still valid
    if (reset && (state == S_STORE_WAIT) && st_ack && head_ok)
      pop = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= S_RUN;
      fcnt         <= 4'd0;
      st_commit    <= 1'b0;
      flush        <= 1'b0;
      redirect_pc  <= 32'd0;
      commit_count <= 32'd0;
    end else begin
      if (pop)
        commit_count <= commit_count + 32'd1;
      case (state)
        S_RUN: begin
          if (eligible && (cls == CLS_STORE)) begin
            st_commit <= 1'b1;
            state     <= S_STORE_WAIT;
          end else if (eligible && (cls == CLS_CTRL) && mispredict) begin
            redirect_pc <= head_val;
            flush       <= 1'b1;
            fcnt        <= 4'd0;
            state       <= S_FLUSH;
          end
        end
        S_STORE_WAIT: begin
          if (st_ack && head_ok) begin
            st_commit <= 1'b0;
            state     <= S_RUN;
          end
        end
        S_FLUSH: begin
          if (fcnt == FLUSH_LAST) begin
            flush <= 1'b0;
            state <= S_RUN;
          end else begin
            fcnt <= fcnt + 4'd1;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Commit unit bench: directed vectors with literal checks plus a
// per-cycle comparison against a behavioural retirement model.
module tb_commit_unit;

  localparam int FC = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        is_empty;
  logic        head_ready;
  logic [31:0] head_instr;
  logic [31:0] head_val;
  logic        stall;
  logic        st_ack;
  logic        pop;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        st_commit;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] commit_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  commit_unit #(.FLUSH_CYCLES(FC)) dut (
    .clock        (clock),
    .reset        (reset),
    .is_empty     (is_empty),
    .head_ready   (head_ready),
    .head_instr   (head_instr),
    .head_val     (head_val),
    .stall        (stall),
    .st_ack       (st_ack),
    .pop          (pop),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .st_commit    (st_commit),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .commit_count (commit_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op,
                                     input logic [4:0] rd);
    return {op, rd, 22'h2A5A5};
  endfunction

  // 0 nop, 1 reg-write, 2 store, 3 control
  function automatic int kind(input logic [4:0] op);
    case (op)
      5'b00000, 5'b00101, 5'b01000, 5'b00011, 5'b10101: return 1;
      5'b00111: return 2;
      5'b00001, 5'b00010, 5'b00100, 5'b00110, 5'b10110: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [4:0] target(input logic [31:0] ins);
    if (ins[31:27] == 5'b00011) return 5'd31;
    if (ins[31:27] == 5'b10101) return 5'd30;
    return ins[26:22];
  endfunction

  // behavioural model: pending store, remaining flush cycles, counters
  bit          m_store = 0, n_store;
  int          m_fleft = 0, n_fleft;
  logic [31:0] m_redir = 0, n_redir;
  logic [31:0] m_count = 0, n_count;

  always @(negedge clock) begin
    bit e_pop, e_we, ok;
    int k;
    logic [4:0] wa;
    e_pop = 0; e_we = 0;
    ok = !is_empty && head_ready;
    k = kind(head_instr[31:27]);
    wa = target(head_instr);
    n_store = m_store; n_fleft = m_fleft;
    n_redir = m_redir; n_count = m_count;
    chk("st_commit", {31'd0, st_commit}, {31'd0, m_store});
    chk("flush", {31'd0, flush}, {31'd0, m_fleft > 0});
    chk("redirect_pc", redirect_pc, m_redir);
    chk("commit_count", commit_count, m_count);
    if (!reset) begin
      e_pop = 0;
    end else if (m_fleft > 0) begin
      n_fleft = m_fleft - 1;
    end else if (m_store) begin
      e_pop = st_ack && ok;
      if (e_pop) n_store = 0;
    end else if (ok && !stall) begin
      if (k == 2) n_store = 1;
      else begin
        e_pop = 1;
        e_we = (k != 3) && (wa != 0);
        if (k == 3 && head_val != 32'hFFFFFFFF) begin
          n_fleft = FC;
          n_redir = head_val;
        end
      end
    end
    if (e_pop) n_count = m_count + 1;
    if (!reset) begin
      n_store = 0; n_fleft = 0; n_redir = 0; n_count = 0;
    end
    chk("pop", {31'd0, pop}, {31'd0, e_pop});
    chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
    if (e_we) begin
      chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, wa});
      chk("rf_wdata", rf_wdata, head_val);
    end
  end

  always @(posedge clock) begin
    m_store <= n_store; m_fleft <= n_fleft;
    m_redir <= n_redir; m_count <= n_count;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic head(input logic [4:0] op, input logic [4:0] rd,
                      input logic [31:0] v);
    head_instr = mk(op, rd);
    head_val   = v;
    is_empty   = 0;
    head_ready = 1;
  endtask

  localparam logic [4:0] OPS [12] = '{5'b00000, 5'b00101, 5'b01000,
    5'b00011, 5'b10101, 5'b00111, 5'b00001, 5'b00010, 5'b00100,
    5'b00110, 5'b10110, 5'b11111};

  initial begin
    reset = 0; is_empty = 1; head_ready = 0; stall = 0; st_ack = 0;
    head_instr = 0; head_val = 0;
    cyc();
    head(5'b00101, 5'd5, 32'h1234);
    #2;
    chk("pop_in_reset", {31'd0, pop}, 32'd0);
    chk("we_in_reset", {31'd0, rf_we}, 32'd0);
    cyc();
    chk("rst_count", commit_count, 32'd0);
    chk("rst_stc", {31'd0, st_commit}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redir", redirect_pc, 32'd0);
    reset = 1;
    #2;
    chk("addi_pop", {31'd0, pop}, 32'd1);
    chk("addi_we", {31'd0, rf_we}, 32'd1);
    chk("addi_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("addi_wdata", rf_wdata, 32'h1234);
    cyc();
    chk("addi_count", commit_count, 32'd1);
    head(5'b00000, 5'd0, 32'h55);
    #2;
    chk("r0_pop", {31'd0, pop}, 32'd1);
    chk("r0_we", {31'd0, rf_we}, 32'd0);
    cyc();
    head(5'b00011, 5'd4, 32'h88);
    #2;
    chk("jal_waddr", {27'd0, rf_waddr}, 32'd31);
    cyc();
    head(5'b10101, 5'd4, 32'h99);
    #2;
    chk("setx_waddr", {27'd0, rf_waddr}, 32'd30);
    cyc();
    chk("count4", commit_count, 32'd4);
    // store with three cycles of back-pressure
    head(5'b00111, 5'd2, 32'hBEEF);
    #2;
    chk("sw_nopop", {31'd0, pop}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      stall = (i == 1);
      #2;
      chk("sw_wait_stc", {31'd0, st_commit}, 32'd1);
      chk("sw_wait_pop", {31'd0, pop}, 32'd0);
    end
    cyc();
    stall = 0; st_ack = 1;
    #2;
    chk("sw_ack_stc", {31'd0, st_commit}, 32'd1);
    chk("sw_ack_pop", {31'd0, pop}, 32'd1);
    cyc();
    st_ack = 0;
    chk("sw_done_stc", {31'd0, st_commit}, 32'd0);
    chk("sw_count", commit_count, 32'd5);
    // mispredicted branch
    head(5'b00010, 5'd0, 32'h40);
    #2;
    chk("bne_pop", {31'd0, pop}, 32'd1);
    cyc();
    head(5'b00101, 5'd6, 32'h7);
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("fl_flush", {31'd0, flush}, 32'd1);
      chk("fl_redir", redirect_pc, 32'h40);
      chk("fl_pop", {31'd0, pop}, 32'd0);
      cyc();
    end
    chk("fl_end", {31'd0, flush}, 32'd0);
    head(5'b00010, 5'd0, 32'hFFFFFFFF);
    #2;
    chk("bne_ok_pop", {31'd0, pop}, 32'd1);
    cyc();
    chk("bne_ok_flush", {31'd0, flush}, 32'd0);
    chk("count7", commit_count, 32'd7);
    // empty / stalled heads never retire
    head(5'b00101, 5'd3, 32'h1);
    is_empty = 1;
    repeat (4) begin
      #2; chk("empty_pop", {31'd0, pop}, 32'd0); cyc();
    end
    is_empty = 0; stall = 1;
    repeat (4) begin
      #2; chk("stall_pop", {31'd0, pop}, 32'd0); cyc();
    end
    stall = 0;
    // ack while the ROB looks empty is ignored
    head(5'b00111, 5'd1, 32'h2);
    cyc();
    is_empty = 1; st_ack = 1;
    #2;
    chk("sw_empty_pop", {31'd0, pop}, 32'd0);
    cyc();
    st_ack = 0;
    chk("sw_empty_stc", {31'd0, st_commit}, 32'd1);
    is_empty = 0;
    reset = 0;
    cyc();
    reset = 1;
    chk("rst_sw_stc", {31'd0, st_commit}, 32'd0);
    chk("rst_sw_count", commit_count, 32'd0);
    // mixed traffic checked by the model only
    for (int i = 0; i < 300; i++) begin
      head(OPS[$urandom_range(0, 11)], 5'($urandom_range(0, 31)),
           $urandom());
      if ($urandom_range(0, 1) == 1 && kind(head_instr[31:27]) == 3)
        head_val = 32'hFFFFFFFF;
      is_empty   = ($urandom_range(0, 7) == 0);
      head_ready = ($urandom_range(0, 5) != 0);
      stall      = ($urandom_range(0, 5) == 0);
      st_ack     = ($urandom_range(0, 2) == 0);
      reset      = ($urandom_range(0, 40) != 0);
      cyc();
    end
    reset = 1;
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
